// File: rtl/block_dispatch.sv
// block_dispatch
//   Splits a kernel of total_threads threads into blocks of THREADS_PER_BLOCK
//   and hands the blocks to NUM_CORES compute cores, one dispatch per cycle,
//   using a round-robin search for a free core.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   reset             asynchronous active-high reset
//   start             level; a kernel runs while high, dropping it aborts
//   total_threads     kernel thread count, sampled when a kernel is accepted
//   core_done         per-core "block finished"
//   core_start        per-core, high while the core owns a block
//   core_reset        per-core one-cycle reset pulse
//   core_block_id     block id assigned to each core
//   core_thread_count valid threads in each core's assigned block
//   done              kernel complete, held until start drops
//   busy              high while resetting cores or running
module block_dispatch #(
  parameter  int NUM_CORES         = 2,
  parameter  int THREADS_PER_BLOCK = 4,
  localparam int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           total_threads,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] core_reset,
  output logic [7:0]           core_block_id     [NUM_CORES],
  output logic [TC_BITS-1:0]   core_thread_count [NUM_CORES],
  output logic                 done,
  output logic                 busy
);

  localparam int PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {IDLE, RESET_CORES, RUN, DONE} state_t;
  typedef enum logic [1:0] {FREE, ASSIGNED, RELEASE} slot_t;

  state_t           state;
  slot_t            slot [NUM_CORES];
  logic [PTR_W-1:0] rr_ptr;
  logic [7:0]       total_lat;
  logic [7:0]       total_blocks;
  logic [7:0]       next_block;
  logic [7:0]       blocks_done;

  logic             found;
  logic [PTR_W-1:0] pick;
  logic [7:0]       done_cnt;

  function automatic int wrap_idx(input int a);
    return (a >= NUM_CORES) ? a - NUM_CORES : a;
  endfunction

  // Only the final block can be partial; every other block is full.
  function automatic logic [TC_BITS-1:0] block_threads(input logic [7:0] total,
                                                       input logic [7:0] blk);
    int rem;
    rem = int'(total) - int'(blk) * THREADS_PER_BLOCK;
    if (rem > 0 && rem < THREADS_PER_BLOCK) return TC_BITS'(rem);
    return TC_BITS'(THREADS_PER_BLOCK);
  endfunction

  // Round-robin search for the first FREE slot starting at rr_ptr. A slot in
  // RELEASE is not FREE, so a core that just finished is skipped this cycle.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && slot[wrap_idx(int'(rr_ptr) + i)] == FREE) begin
        found = 1'b1;
        pick  = PTR_W'(wrap_idx(int'(rr_ptr) + i));
      end
    end
  end

  // Number of completions accepted this cycle (only ASSIGNED slots count).
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (slot[i] == ASSIGNED && core_done[i]) done_cnt = done_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      total_lat    <= '0;
      total_blocks <= '0;
      next_block   <= '0;
      blocks_done  <= '0;
      core_start   <= '0;
      core_reset   <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot[i]              <= FREE;
        core_block_id[i]     <= '0;
        core_thread_count[i] <= '0;
      end
    end else begin
      core_reset <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            total_lat    <= total_threads;
            total_blocks <= 8'((9'(total_threads) + 9'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB);
            next_block   <= '0;
            blocks_done  <= '0;
            core_reset   <= '1;
            done         <= 1'b0;
            busy         <= 1'b1;
            state        <= RESET_CORES;
          end
        end
        RESET_CORES, RUN: begin
          if (!start) begin
            // Abort wins over everything else.
            core_reset <= '1;
            core_start <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
            for (int i = 0; i < NUM_CORES; i++) slot[i] <= FREE;
          end else if (state == RESET_CORES) begin
            state <= RUN;
            for (int i = 0; i < NUM_CORES; i++) slot[i] <= FREE;
          end else if (blocks_done == total_blocks) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (slot[i] == ASSIGNED && core_done[i]) begin
                core_start[i] <= 1'b0;
                core_reset[i] <= 1'b1;
                slot[i]       <= RELEASE;
              end else if (slot[i] == RELEASE) begin
                slot[i] <= FREE;
              end
            end
            blocks_done <= blocks_done + done_cnt;
            if (next_block < total_blocks && found) begin
              core_block_id[pick]     <= next_block;
              core_thread_count[pick] <= block_threads(total_lat, next_block);
              core_start[pick]        <= 1'b1;
              slot[pick]              <= ASSIGNED;
              next_block              <= next_block + 8'd1;
              rr_ptr <= (int'(pick) == NUM_CORES - 1) ? '0 : pick + 1'b1;
            end
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatch.sv
module tb_block_dispatch;
  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCB = $clog2(TPB) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [7:0]     total_threads = '0;
  logic [NC-1:0]  core_done = '0;
  logic [NC-1:0]  core_start;
  logic [NC-1:0]  core_reset;
  logic [7:0]     core_block_id [NC];
  logic [TCB-1:0] core_thread_count [NC];
  logic           done;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  block_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk(clk), .reset(reset), .start(start), .total_threads(total_threads),
    .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 cores being reset, 2 running, 3 finished
  // own:  0 free, 1 holding a block, 2 cooling down after completion
  int m_mode = 0, m_total = 0, m_nblk = 0, m_issued = 0, m_finished = 0, m_ptr = 0;
  int m_own [NC];
  bit [NC-1:0] e_start = '0, e_reset = '0;
  int e_id [NC], e_cnt [NC];
  bit e_done = 1'b0, e_busy = 1'b0;

  initial for (int c = 0; c < NC; c++) begin m_own[c] = 0; e_id[c] = 0; e_cnt[c] = 0; end

  task automatic m_abort();
    e_reset = '1; e_start = '0; e_done = 1'b0; e_busy = 1'b0; m_mode = 0;
    for (int c = 0; c < NC; c++) m_own[c] = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_ptr = 0; e_start = '0; e_reset = '0; e_done = 1'b0; e_busy = 1'b0;
      for (int c = 0; c < NC; c++) begin m_own[c] = 0; e_id[c] = 0; e_cnt[c] = 0; end
    end else begin
      e_reset = '0;
      if (m_mode == 0) begin
        if (start) begin
          m_total = total_threads; m_nblk = (m_total + TPB - 1) / TPB;
          m_issued = 0; m_finished = 0; e_reset = '1; e_busy = 1'b1; e_done = 1'b0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (!start) m_abort();
        else begin
          m_mode = 2;
          for (int c = 0; c < NC; c++) m_own[c] = 0;
        end
      end else if (m_mode == 2) begin
        if (!start) m_abort();
        else if (m_finished == m_nblk) begin
          m_mode = 3; e_done = 1'b1; e_busy = 1'b0;
        end else begin
          bit [NC-1:0] avail;
          for (int c = 0; c < NC; c++) avail[c] = (m_own[c] == 0);
          for (int c = 0; c < NC; c++) begin
            if (m_own[c] == 1 && core_done[c]) begin
              m_finished++; m_own[c] = 2; e_start[c] = 1'b0; e_reset[c] = 1'b1;
            end else if (m_own[c] == 2) m_own[c] = 0;
          end
          if (m_issued < m_nblk) begin
            for (int k = 0; k < NC; k++) begin
              int c;
              c = (m_ptr + k) % NC;
              if (avail[c]) begin
                e_id[c]  = m_issued;
                e_cnt[c] = (m_total - m_issued * TPB < TPB) ? m_total - m_issued * TPB : TPB;
                e_start[c] = 1'b1; m_own[c] = 1; m_issued++; m_ptr = (c + 1) % NC;
                break;
              end
            end
          end
        end
      end else begin
        if (!start) begin m_mode = 0; e_done = 1'b0; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("core_start", 32'(core_start), 32'(e_start));
      chk("core_reset", 32'(core_reset), 32'(e_reset));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("core_block_id[%0d]", c), 32'(core_block_id[c]), 32'(e_id[c]));
        chk($sformatf("core_thread_count[%0d]", c), 32'(core_thread_count[c]), 32'(e_cnt[c]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input logic s, input logic [NC-1:0] cd);
    start = s; core_done = cd;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset core_start", 32'(core_start), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // total_threads = 8: two full blocks, simultaneous completion
    total_threads = 8'd8;
    tick(1, 2'b00);
    chk("t8 core_reset after launch", 32'(core_reset), 32'b11);
    chk("t8 busy after launch", 32'(busy), 32'd1);
    tick(1, 2'b00);
    chk("t8 core_start in reset phase", 32'(core_start), 32'b00);
    tick(1, 2'b00);
    chk("t8 core_start edge2", 32'(core_start), 32'b01);
    chk("t8 block id core0", 32'(core_block_id[0]), 32'd0);
    chk("t8 count core0", 32'(core_thread_count[0]), 32'd4);
    tick(1, 2'b00);
    chk("t8 core_start edge3", 32'(core_start), 32'b11);
    chk("t8 block id core1", 32'(core_block_id[1]), 32'd1);
    chk("t8 count core1", 32'(core_thread_count[1]), 32'd4);
    tick(1, 2'b00);
    tick(1, 2'b11);
    chk("t8 dual release", 32'(core_reset), 32'b11);
    chk("t8 done not yet", 32'(done), 32'd0);
    tick(1, 2'b00);
    chk("t8 done next cycle", 32'(done), 32'd1);
    tick(0, 2'b00);
    chk("t8 done cleared", 32'(done), 32'd0);
    tick(0, 2'b00);

    // total_threads = 10: partial last block goes to core1 after it finishes first
    total_threads = 8'd10;
    tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00);
    tick(1, 2'b10);
    chk("t10 core1 released", 32'(core_reset), 32'b10);
    tick(1, 2'b10);   // core_done on a RELEASE slot is ignored
    chk("t10 no redispatch yet", 32'(core_start), 32'b01);
    tick(1, 2'b00);
    chk("t10 core_start", 32'(core_start), 32'b11);
    chk("t10 block id core1", 32'(core_block_id[1]), 32'd2);
    chk("t10 partial count", 32'(core_thread_count[1]), 32'd2);
    tick(1, 2'b01);
    tick(1, 2'b10);
    chk("t10 done before last", 32'(done), 32'd0);
    tick(1, 2'b00);
    chk("t10 done", 32'(done), 32'd1);
    tick(0, 2'b00); tick(0, 2'b00);

    // total_threads = 0: straight to done, no relaunch while start held
    total_threads = 8'd0;
    tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00);
    chk("t0 done", 32'(done), 32'd1);
    chk("t0 no core_start", 32'(core_start), 32'd0);
    tick(1, 2'b00);
    chk("t0 done held", 32'(done), 32'd1);
    tick(0, 2'b00);
    chk("t0 done cleared", 32'(done), 32'd0);
    tick(0, 2'b00);

    // abort while both cores own blocks
    total_threads = 8'd8;
    tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00);
    tick(0, 2'b00);
    chk("abort core_reset", 32'(core_reset), 32'b11);
    chk("abort core_start", 32'(core_start), 32'b00);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    tick(0, 2'b00);
    chk("abort pulse ends", 32'(core_reset), 32'b00);

    // asynchronous reset mid-run, then relaunch on the first edge after release
    tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00); tick(1, 2'b00);
    #2 reset = 1'b1;
    #1;
    chk("async core_start", 32'(core_start), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async block id core1", 32'(core_block_id[1]), 32'd0);
    chk("async count core0", 32'(core_thread_count[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1, 2'b00);
    chk("relaunch core_reset", 32'(core_reset), 32'b11);
    tick(1, 2'b00); tick(1, 2'b00);
    chk("relaunch core_start", 32'(core_start), 32'b01);
    tick(0, 2'b00); tick(0, 2'b00);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_dispatch.md
BLOCK_DISPATCH -- requirements
Module: block_dispatch

Interface
REQ-001 The module SHALL have parameter NUM_CORES, default 2, meaning the number of compute cores served.
REQ-002 The module SHALL have parameter THREADS_PER_BLOCK, default 4, meaning the maximum threads per block; it SHALL be a power of two, at least 1.
REQ-003 The module SHALL have localparam TC_BITS = $clog2(THREADS_PER_BLOCK)+1, meaning the width of the per-core thread count.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The module SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-007 The module SHALL have port start, input, 1 bit, a level; a kernel runs while it is high.
REQ-008 The module SHALL have port total_threads, input, 8 bits, the kernel thread count, sampled when a kernel is accepted.
REQ-009 The module SHALL have port core_done, input, NUM_CORES bits, meaning the per-core block has finished.
REQ-010 The module SHALL have port core_start, output, NUM_CORES bits, held high while the core owns a block.
REQ-011 The module SHALL have port core_reset, output, NUM_CORES bits, a one-cycle per-core reset pulse.
REQ-012 The module SHALL have port core_block_id, output, 8 bits x NUM_CORES (unpacked array), the block id assigned to each core.
REQ-013 The module SHALL have port core_thread_count, output, TC_BITS x NUM_CORES (unpacked array), the valid threads in the assigned block.
REQ-014 The module SHALL have port done, output, 1 bit, meaning the kernel is complete.
REQ-015 The module SHALL have port busy, output, 1 bit, high in states RESET_CORES and RUN.

Function
REQ-016 The top-level state machine SHALL have states IDLE, RESET_CORES, RUN and DONE.
REQ-017 In IDLE with start=1, the module SHALL latch total_threads, compute total_blocks = ceil(total_threads/THREADS_PER_BLOCK) (8 bits), clear next_block and blocks_done, pulse all core_reset bits, and go to RESET_CORES.
REQ-018 RESET_CORES SHALL last exactly one cycle and then go to RUN.
REQ-019 Each core SHALL have a slot state FREE, ASSIGNED or RELEASE; all slots SHALL be FREE on entering RUN.
REQ-020 In RUN, while next_block < total_blocks, at most one block SHALL be dispatched per cycle, to the first FREE core found by round-robin search starting at rr_ptr.
REQ-021 After a dispatch, rr_ptr SHALL become the chosen core index + 1, wrapping to 0 after NUM_CORES-1.
REQ-022 On dispatch, the module SHALL register core_block_id = next_block and core_start = 1, set the slot to ASSIGNED, and increment next_block.
REQ-023 On dispatch, core_thread_count SHALL be THREADS_PER_BLOCK, except for the last block: total_threads - next_block*THREADS_PER_BLOCK when that value is nonzero and less than THREADS_PER_BLOCK.
REQ-024 core_done SHALL be ignored for any slot that is not ASSIGNED.
REQ-025 When core_done is high for an ASSIGNED slot, the module SHALL clear core_start, assert that core's core_reset for one cycle, set the slot to RELEASE, and increment blocks_done.
REQ-026 Simultaneous core_done on k cores SHALL add k to blocks_done in the same cycle.
REQ-027 A RELEASE slot SHALL become FREE on the next cycle and SHALL NOT be chosen for dispatch in the cycle its core_done is accepted.
REQ-028 In RUN, when blocks_done == total_blocks and start=1, the module SHALL go to DONE.
REQ-029 When total_threads = 0, the first RUN cycle SHALL go directly to DONE with no dispatch.
REQ-030 DONE SHALL hold done=1 until start=0, then go to IDLE with done=0; there SHALL be no relaunch until start has been observed low.
REQ-031 Abort: start=0 in RESET_CORES or RUN SHALL pulse core_reset on all cores, clear core_start, set all slots FREE, and go to IDLE with done=0; this SHALL take priority over dispatch and over REQ-028.
REQ-032 Block id arithmetic SHALL be unsigned 8-bit; next_block SHALL never exceed total_blocks.

Reset
REQ-033 reset=1 SHALL immediately (asynchronously) force state IDLE, all slots FREE, and rr_ptr=0.
REQ-034 Under reset, core_start, core_reset, done, busy, every core_block_id and every core_thread_count SHALL be 0.
REQ-035 Deasserting reset with start=1 SHALL launch a kernel on the first clock edge that samples start.

Verification (NUM_CORES=2, THREADS_PER_BLOCK=4)
REQ-036 total_threads=8, start=1 at edge 0 -> core_reset=2'b11 after edge 0; core0 gets block 0 (count 4) after edge 2; core1 gets block 1 (count 4) after edge 3; both core_done -> done=1.
REQ-037 total_threads=10, core1 done before core0 -> block 2 goes to core1 with core_thread_count=2, 2 cycles after its core_done; done follows the last core_done.
REQ-038 total_threads=0 -> no core_start; done=1 after edge 2; start=0 -> IDLE, done=0.
REQ-039 start dropped while both cores are ASSIGNED -> core_reset=2'b11 for one cycle, core_start=0, done stays 0, busy=0.
REQ-040 core_done=2'b11 in the same cycle -> blocks_done increases by 2; with total_threads=8, done is asserted on the next cycle.
REQ-041 reset asserted mid-RUN between clock edges -> all outputs 0 before the next clk edge.
